// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp32_pkg
// Purpose  : IEEE-754 single-precision field widths, constants and shared types
// Revision : 1.0
// ============================================================================
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // Extended mantissa: hidden 1 + MAN_W + guard + round + sticky
    localparam int XM_W = MAN_W + 4;
    // Working exponent wide enough to see overflow past 255
    localparam int XE_W = EXP_W + 2;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ADD    = 3'd3,
        ST_NORM   = 3'd4,
        ST_ROUND  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } fp32_t;

endpackage
`default_nettype wire

// File: rtl/fp32_round.sv
`default_nettype none
// ============================================================================
// Module   : fp32_round
// Purpose  : Round-to-nearest-even of an extended mantissa plus overflow-to-inf
// Revision : 1.0
// ============================================================================
module fp32_round
    import fp32_pkg::*;
(
    input  logic            sign,
    input  logic [XE_W-1:0] exp,
    input  logic [XM_W-1:0] mant,
    output logic [31:0]     result
);

    logic             w_up;
    logic [MAN_W+1:0] w_rnd;
    logic [XE_W-1:0]  w_exp;
    logic [MAN_W-1:0] w_frac;

    always_comb begin
        // mant[3] is the kept lsb, [2:0] are guard/round/sticky
        w_up  = mant[2] & (mant[1] | mant[0] | mant[3]);
        w_rnd = {1'b0, mant[XM_W-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
        if (w_rnd[MAN_W+1]) begin
            w_exp  = exp + XE_W'(1);
            w_frac = w_rnd[MAN_W:1];
        end else begin
            w_exp  = exp;
            w_frac = w_rnd[MAN_W-1:0];
        end
        if (w_exp >= XE_W'(255)) begin
            result = sign ? NEG_INF : POS_INF;
        end else begin
            result = {sign, w_exp[EXP_W-1:0], w_frac};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_iter.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_iter
// Purpose  : Multi-cycle FP32 add/subtract, one-bit-per-cycle align/normalize
// Revision : 1.0
// ============================================================================
module fp_addsub_iter
    import fp32_pkg::*;
#(
    parameter int MAX_ALIGN = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam logic [EXP_W-1:0] c_max_align = EXP_W'(MAX_ALIGN);

    state_t           r_state;
    state_t           w_next;

    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_result;
    logic             r_sign;
    logic             r_eff_sub;
    logic [XE_W-1:0]  r_exp;
    logic [XM_W-1:0]  r_big;
    logic [XM_W-1:0]  r_small;
    logic [XM_W:0]    r_sum;
    logic [EXP_W-1:0] r_cnt;

    fp32_t            w_fa;
    fp32_t            w_fb;
    fp32_t            w_big;
    fp32_t            w_sml;
    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_a_inf;
    logic             w_b_inf;
    logic             w_a_nan;
    logic             w_b_nan;
    logic             w_a_ge;
    logic             w_special;
    logic [31:0]      w_special_res;
    logic [EXP_W-1:0] w_diff;
    logic [XM_W:0]    w_sum;
    logic             w_carry;
    logic             w_normed;
    logic             w_align_last;
    logic [31:0]      w_round_res;

    // Operand classification and magnitude ordering for the UNPACK step
    always_comb begin
        w_fa          = r_a;
        w_fb          = r_b;
        w_a_zero      = (w_fa.exp == '0);
        w_b_zero      = (w_fb.exp == '0);
        w_a_inf       = (w_fa.exp == '1) && (w_fa.mant == '0);
        w_b_inf       = (w_fb.exp == '1) && (w_fb.mant == '0);
        w_a_nan       = (w_fa.exp == '1) && (w_fa.mant != '0);
        w_b_nan       = (w_fb.exp == '1) && (w_fb.mant != '0);
        w_special     = 1'b1;
        w_special_res = '0;
        if (w_a_nan || w_b_nan) begin
            w_special_res = QNAN;
        end else if (w_a_inf && w_b_inf) begin
            w_special_res = (w_fa.sign == w_fb.sign) ? r_a : QNAN;
        end else if (w_a_inf) begin
            w_special_res = r_a;
        end else if (w_b_inf) begin
            w_special_res = r_b;
        end else if (w_a_zero && w_b_zero) begin
            w_special_res = {w_fa.sign & w_fb.sign, 31'b0};
        end else if (w_a_zero) begin
            w_special_res = r_b;
        end else if (w_b_zero) begin
            w_special_res = r_a;
        end else begin
            w_special = 1'b0;
        end
        w_a_ge = {w_fa.exp, w_fa.mant} >= {w_fb.exp, w_fb.mant};
        w_big  = w_a_ge ? w_fa : w_fb;
        w_sml  = w_a_ge ? w_fb : w_fa;
        w_diff = w_big.exp - w_sml.exp;
    end

    always_comb begin
        if (r_eff_sub) begin
            w_sum = {1'b0, r_big} - {1'b0, r_small};
        end else begin
            w_sum = {1'b0, r_big} + {1'b0, r_small};
        end
        w_carry      = r_sum[XM_W];
        w_normed     = r_sum[XM_W-1];
        w_align_last = (r_cnt > c_max_align) || (r_cnt <= EXP_W'(1));
    end

    fp32_round u_round (
        .sign   (r_sign),
        .exp    (r_exp),
        .mant   (r_sum[XM_W-1:0]),
        .result (w_round_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid) w_next = ST_UNPACK;
            ST_UNPACK: begin
                if (w_special)           w_next = ST_DONE;
                else if (w_diff == '0)   w_next = ST_ADD;
                else                     w_next = ST_ALIGN;
            end
            ST_ALIGN:  if (w_align_last) w_next = ST_ADD;
            ST_ADD: begin
                if (w_sum == '0)                      w_next = ST_DONE;
                else if (w_sum[XM_W:XM_W-1] == 2'b01) w_next = ST_ROUND;
                else                                  w_next = ST_NORM;
            end
            ST_NORM: begin
                if (w_carry || w_normed)        w_next = ST_ROUND;
                else if (r_exp <= XE_W'(1))     w_next = ST_DONE;
            end
            ST_ROUND:  w_next = ST_DONE;
            ST_DONE:   if (out_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        busy      = (r_state != ST_IDLE);
        out_valid = (r_state == ST_DONE);
        result    = r_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_exp     <= '0;
            r_big     <= '0;
            r_small   <= '0;
            r_sum     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a <= a;
                        r_b <= {b[31] ^ op, b[30:0]};
                    end
                end
                ST_UNPACK: begin
                    if (w_special) r_result <= w_special_res;
                    r_sign    <= w_big.sign;
                    r_eff_sub <= w_big.sign ^ w_sml.sign;
                    r_exp     <= {2'b00, w_big.exp};
                    r_big     <= {1'b1, w_big.mant, 3'b000};
                    r_small   <= {1'b1, w_sml.mant, 3'b000};
                    r_cnt     <= w_diff;
                end
                ST_ALIGN: begin
                    // Beyond the alignment window only the sticky bit survives
                    if (r_cnt > c_max_align) begin
                        r_small <= XM_W'(1);
                        r_cnt   <= '0;
                    end else begin
                        r_small <= {1'b0, r_small[XM_W-1:2], r_small[1] | r_small[0]};
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                ST_ADD: begin
                    if (w_sum == '0) r_result <= '0;
                    else             r_sum    <= w_sum;
                end
                ST_NORM: begin
                    if (w_carry) begin
                        r_sum <= {1'b0, r_sum[XM_W:2], r_sum[1] | r_sum[0]};
                        r_exp <= r_exp + XE_W'(1);
                    end else if (!w_normed) begin
                        if (r_exp <= XE_W'(1)) begin
                            r_result <= {r_sign, 31'b0};
                        end else begin
                            r_sum <= {r_sum[XM_W-1:0], 1'b0};
                            r_exp <= r_exp - XE_W'(1);
                        end
                    end
                end
                ST_ROUND: r_result <= w_round_res;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_iter
// Purpose  : Scoreboard bench for fp_addsub_iter
// Revision : 1.0
// ============================================================================
module tb_fp_addsub_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];

    fp_addsub_iter #(.MAX_ALIGN(26)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                        input logic [31:0] expv, input bit push);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        a        = ta;
        b        = tb_v;
        op       = top;
        in_valid = 1'b1;
        if (push) sb_q.push_back(expv);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic receive(input string tag, output int lat);
        logic [31:0] expv;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, {31'b0, out_valid}, 32'd1);
            if (sb_q.size() != 0) expv = sb_q.pop_front();
        end else if (sb_q.size() == 0) begin
            check({tag, "_unexpected"}, {31'b0, out_valid}, 32'd0);
        end else begin
            expv = sb_q.pop_front();
            check(tag, result, expv);
        end
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic top, input logic [31:0] expv, output int lat);
        send(ta, tb_v, top, expv, 1'b1);
        receive(tag, lat);
    endtask

    initial begin
        int lat;
        int wait_n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result",    result,             32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        rst = 1'b0;

        run("add_1p2", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, lat);
        check("lat_1p2", {31'b0, (lat <= 4)}, 32'd1);
        run("sub_3m1",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, lat);
        run("sub_eq",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, lat);
        run("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, lat);
        check("lat_special", {31'b0, (lat <= 2)}, 32'd1);
        run("ovf_max",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, lat);
        run("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, lat);
        run("tie_up",    32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, lat);
        run("negz_negz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, lat);
        run("nan_in",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, lat);
        run("inf_fin",   32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, lat);
        run("cancel",    32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, lat);
        run("collapse",  32'h3F800000, 32'h00800000, 1'b1, 32'h3F800000, lat);
        run("flush_neg", 32'h80800001, 32'h80800000, 1'b1, 32'h80000000, lat);
        run("round_ovf", 32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, lat);
        run("neg_sum",   32'hC0000000, 32'hBF800000, 1'b0, 32'hC0400000, lat);
        run("carry_eq",  32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, lat);

        // Back-pressure with a competing request held while the unit is busy
        out_ready = 1'b0;
        send(32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 1'b1);
        a        = 32'h3F800000;
        b        = 32'h3F800000;
        op       = 1'b0;
        in_valid = 1'b1;
        wait_n   = 0;
        while (!out_valid && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result",   result,              32'h40C00000);
            check("bp_in_ready", {31'b0, in_ready},   32'd0);
            check("bp_hold",     {31'b0, out_valid},  32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        receive("bp_deliver", lat);
        repeat (3) @(negedge clk);
        check("bp_idle_busy", {31'b0, busy},      32'd0);
        check("bp_no_extra",  {31'b0, out_valid}, 32'd0);

        // Abort an operation in the middle of alignment
        send(32'h4B000000, 32'h3F800000, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_align_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'b0, in_ready},  32'd1);
        check("abort_busy",      {31'b0, busy},      32'd0);
        rst = 1'b0;
        run("after_abort", 32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, lat);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_addsub_iter.md
Name: fp_addsub_iter

Overview:
- Multi-cycle IEEE-754 single-precision add/subtract unit with a valid/ready handshake on both sides.
- It is the sequential, bidirectional counterpart of the combinational FAdd. It covers subtraction (the other direction) as well as addition and registers its result.
- Alignment and normalization shifts run one bit per cycle, trading latency for area.
- It sits beside FAdd in float_adder/ and is exercised by the same style of self-checking bench.

Parameters:
- MAX_ALIGN, 26: largest alignment shift performed. Larger exponent differences collapse the smaller operand into the sticky bit.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  unit can accept operands (high only in IDLE)
- a  in  32  operand A, IEEE-754 single
- b  in  32  operand B, IEEE-754 single
- op  in  1  0 = a+b, 1 = a-b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  IEEE-754 single result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0. Reset mid-operation aborts the operation and discards the result.
- Accept: on in_valid && in_ready, capture a, b and op. For subtraction, b's sign is inverted at capture. Go to UNPACK.
- UNPACK (1 cycle):
  - Split sign, exponent and mantissa; implicit 1 for exp!=0.
  - Denormal inputs (exp==0) are treated as signed zero.
  - Specials decide the result immediately and go to DONE:
    - any NaN -> 0x7FC00000
    - inf + (-inf) -> 0x7FC00000
    - inf with finite -> that inf
    - both zero -> +0, except (-0)+(-0) -> -0
  - Otherwise swap operands so the larger magnitude is first, set the shift count to the exponent difference, and go to ALIGN.
- ALIGN: shift the smaller 27-bit extended mantissa (24 bits + guard + round, with sticky ORed in) right one bit per cycle until the count reaches 0. If the difference exceeds MAX_ALIGN, load mantissa=0 with sticky=1 in one cycle.
- ADD (1 cycle):
  - Same signs: add magnitudes. Different signs: subtract smaller from larger.
  - Sign is that of the larger magnitude.
  - An exact zero difference yields +0 and goes to DONE.
- NORM:
  - On carry-out, shift right 1 (preserving sticky) and exp+1 in one cycle.
  - Otherwise shift left one bit per cycle, exp-1 each cycle, until bit 23 is set.
  - If exp reaches 0 before normalization completes, flush to signed zero and go to DONE.
- ROUND (1 cycle):
  - Round to nearest, ties to even, using guard, round and sticky.
  - A rounding carry renormalizes with exp+1.
  - exp>=255 gives signed inf.
- DONE: result registered, out_valid=1. It holds until out_ready; on that handshake out_valid=0 and the unit returns to IDLE. in_ready stays low throughout DONE, so there is no accept in the same cycle as delivery.
- Latency: accept to out_valid takes 4 cycles minimum for equal exponents with no normalization. The worst case is about 4+26+24 cycles. Specials take 2 cycles.
- Stable outputs: result and out_valid stay constant while out_valid && !out_ready.
- in_valid asserted while busy is ignored. Operands are not latched.

Decomposition:
- Package fp32_pkg: field widths (EXP_W=8, MAN_W=23), BIAS=127, constants QNAN=0x7FC00000, POS_INF=0x7F800000 and NEG_INF=0xFF800000, the state enum, and a typedef for the unpacked {sign, exp, mant} struct.
- Sub-module fp32_round: combinational round-to-nearest-even plus the overflow-to-inf check. The same module is reusable by FAdd.

Test Plan:
- a=0x3F800000, b=0x40000000, op=0 (1.0+2.0) -> result=0x40400000 (3.0), out_valid within 4 cycles of accept.
- a=0x40400000, b=0x3F800000, op=1 (3.0-1.0) -> 0x40000000. Then a=b=0x3F800000, op=1 -> 0x00000000 (+0).
- a=0x7F800000, b=0x7F800000, op=1 (inf-inf) -> 0x7FC00000 in 2 cycles. a=0x7F7FFFFF, b=0x7F7FFFFF, op=0 -> 0x7F800000.
- a=0x3F800000, b=0x33800000 (1.0 + 2^-24, a tie), op=0 -> 0x3F800000, since the tie rounds to even. b=0x33800001 -> 0x3F800001.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0. A new in_valid during busy is ignored, with the first result delivered unchanged.
- Assert rst in the middle of ALIGN with a=0x4B000000, b=0x3F800000 -> next cycle: IDLE, out_valid=0, in_ready=1. The next operation then completes correctly.
